// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Multicycle 32-bit DIV/DIVU unit for the EX stage. It uses restoring radix-2
// division, one quotient bit per cycle. The unit freezes F/D/E through
// stall_div while a division is in flight, and delivers {HI, LO} on a
// one-cycle ready pulse.
//
// Ports
//   clk         in   pipeline clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   DIV/DIVU present in E (held high while E is stalled)
//   signed_div  in   1 = DIV (two's complement), 0 = DIVU; sampled with start
//   opa         in   dividend; sampled with start
//   opb         in   divisor; sampled with start
//   annul       in   E/M flush; aborts an in-flight division
//   stall_div   out  hold E and earlier stages
//   ready       out  one-cycle pulse, result valid
//   result      out  {remainder (HI), quotient (LO)}
// -----------------------------------------------------------------------------
module divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   input  logic               annul,
   output logic               stall_div,
   output logic               ready,
   output logic [2*WIDTH-1:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [4:0]         r_cnt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic [WIDTH-1:0]   r_opa;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic [2*WIDTH-1:0] r_result;

   logic               w_accept;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_rem_nx;
   logic [WIDTH-1:0]   w_quo_nx;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;
   logic [2*WIDTH-1:0] w_result;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      stall_div = 1'b0;
      ready     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && !annul) begin
               w_next    = S_BUSY;
               stall_div = 1'b1;
            end
         end
         S_BUSY: begin
            stall_div = 1'b1;
            if (annul)              w_next = S_IDLE;
            else if (r_cnt == 5'd31) w_next = S_DONE;
         end
         S_DONE: begin
            // The instruction leaves E this cycle, so a still-high start
            // belongs to the next instruction and is picked up from IDLE.
            ready  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Keep the pipeline free while the reset is held, even though start
      // may already be high.
      if (!resetn) stall_div = 1'b0;
   end

   assign w_accept = (r_state == S_IDLE) && start && !annul;

   // ---------------- datapath ----------------
   // Magnitudes fit in WIDTH bits unsigned: |0x80000000| = 0x80000000.
   assign w_abs_a = (signed_div && opa[WIDTH-1]) ? -opa : opa;
   assign w_abs_b = (signed_div && opb[WIDTH-1]) ? -opb : opb;

   // 33-bit partial remainder for the trial subtraction. When the difference
   // is non-negative it is smaller than the divisor, so its low WIDTH bits
   // are exact.
   assign w_shift  = {r_rem, r_quo[WIDTH-1]};
   assign w_ge     = (w_shift >= {1'b0, r_div});
   assign w_diff   = w_shift[WIDTH-1:0] - r_div;
   assign w_rem_nx = w_ge ? w_diff : w_shift[WIDTH-1:0];
   assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

   // The result is formed from the final step's values, so it is already
   // registered when the FSM enters DONE.
   assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
   assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
   assign w_result = r_dz ? {r_opa, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_opa    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_result <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= w_abs_a;
         r_div    <= w_abs_b;
         r_opa    <= opa;
         r_neg_q  <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
         r_neg_r  <= signed_div && opa[WIDTH-1];
         r_dz     <= (opb == '0);
      end else if (r_state == S_BUSY && !annul) begin
         r_rem <= w_rem_nx;
         r_quo <= w_quo_nx;
         r_cnt <= r_cnt + 5'd1;
         if (r_cnt == 5'd31) r_result <= w_result;
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_divider.sv
module tb_divider;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        signed_div;
   logic        annul;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        stall_div;
   logic        ready;
   logic [63:0] result;

   always #5 clk = ~clk;

   divider #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signed_div),
      .opa        (opa),
      .opb        (opb),
      .annul      (annul),
      .stall_div  (stall_div),
      .ready      (ready),
      .result     (result)
   );

   typedef struct {
      string       name;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t        vecs[10];
   logic [63:0] sb_q[$];
   logic [63:0] last_res;
   int          total = 0;
   int          bad   = 0;

   // Reference: MIPS DIV/DIVU semantics, independent of the shift/subtract.
   function automatic logic [63:0] model(bit s, logic [31:0] a, logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] sq;
      logic signed [31:0] sr;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (!s) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic launch(bit s, logic [31:0] a, logic [31:0] b, logic [63:0] exp);
      signed_div = s;
      opa        = a;
      opb        = b;
      start      = 1'b1;
      sb_q.push_back(exp);
   endtask

   // Called just after the T0 negedge; returns at the negedge where ready
   // is seen (or after the cycle budget runs out).
   task automatic track(string name, output int lat);
      int          stall_bad;
      logic [63:0] exp;
      stall_bad = 0;
      lat       = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            // Operands were latched at the end of T0; disturbing them is harmless.
            opa        = $urandom;
            opb        = $urandom;
            signed_div = ~signed_div;
         end
         if (ready === 1'b1) begin
            lat = k;
            break;
         end
         if (stall_div !== 1'b1) stall_bad++;
      end
      check({name, " stall_busy_errs"}, stall_bad, 0);
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL %s timeout: no ready within 40 cycles", name);
      end else begin
         check({name, " latency"}, lat, 33);
         check({name, " stall_in_done"}, stall_div, 0);
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard: ready with nothing expected", name);
         end else begin
            exp = sb_q.pop_front();
            check({name, " result"}, result, exp);
            last_res = exp;
         end
      end
   endtask

   task automatic single(vec_t v);
      int lat;
      @(negedge clk);
      launch(v.sgn, v.a, v.b, {v.hi, v.lo});
      #1;
      check({v.name, " stall_t0"}, stall_div, 1);
      track(v.name, lat);
      start = 1'b0;
      @(negedge clk);
      check({v.name, " ready_t34"}, ready, 0);
      check({v.name, " stall_t34"}, stall_div, 0);
   endtask

   initial begin
      int          lat;
      int          ready_cnt;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{"divu_100_7",    1'b0, 32'd100,        32'd7,        32'h00000002, 32'h0000000E};
      vecs[1] = '{"div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[2] = '{"div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[3] = '{"div_ovf",       1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4] = '{"divu_5_0",      1'b0, 32'd5,          32'd0,        32'h00000005, 32'hFFFFFFFF};
      vecs[5] = '{"div_m16_0",     1'b1, 32'hFFFFFFF0,   32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
      vecs[6] = '{"divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,        32'h00000000, 32'hFFFFFFFF};
      vecs[7] = '{"div_min_1",     1'b1, 32'h80000000,   32'd1,        32'h00000000, 32'h80000000};
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      vecs[8] = '{"divu_rand", 1'b0, ra, rb, model(1'b0, ra, rb) >> 32, model(1'b0, ra, rb) & 64'hFFFFFFFF};
      ra = $urandom;
      rb = -$urandom_range(1, 1000);
      vecs[9] = '{"div_rand",  1'b1, ra, rb, model(1'b1, ra, rb) >> 32, model(1'b1, ra, rb) & 64'hFFFFFFFF};

      // Reset state; stall must stay low under reset even with start high.
      resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
      last_res = '0;
      #12;
      check("rst ready", ready, 0);
      check("rst result", result, 0);
      start = 1'b1;
      #1;
      check("rst stall_with_start", stall_div, 0);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 10; i++) single(vecs[i]);

      // Annul at T10 of DIVU 50/3: stall drops at T11, no ready, result kept.
      @(negedge clk);
      signed_div = 1'b0; opa = 32'd50; opb = 32'd3; start = 1'b1;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      annul = 1'b1; start = 1'b0;
      #1;
      check("annul stall_t10", stall_div, 1);
      @(negedge clk);
      annul = 1'b0;
      check("annul stall_t11", stall_div, 0);
      // Annul together with start: no stall at all.
      @(negedge clk);
      opa = 32'd77; opb = 32'd5; start = 1'b1; annul = 1'b1;
      #1;
      check("annul_t0 stall", stall_div, 0);
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      check("annul_t0 stall_next", stall_div, 0);
      ready_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready === 1'b1) ready_cnt++;
      end
      check("annul ready_pulses", ready_cnt, 0);
      check("annul result_kept", result, last_res);
      single('{"divu_9_2", 1'b0, 32'd9, 32'd2, 32'd1, 32'd4});

      // Back-to-back with start held high throughout.
      @(negedge clk);
      launch(1'b0, 32'd20, 32'd6, {32'd2, 32'd3});
      #1;
      check("b2b1 stall_t0", stall_div, 1);
      track("b2b1", lat);
      launch(1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF});
      @(negedge clk);
      check("b2b2 stall_t34", stall_div, 1);
      track("b2b2", lat);
      start = 1'b0;
      @(negedge clk);
      check("b2b2 ready_after", ready, 0);

      // Reset at T15 of a division: outputs clear at once, operation dropped.
      @(negedge clk);
      signed_div = 1'b1; opa = 32'hFFFFFF9C; opb = 32'd7; start = 1'b1;
      for (int k = 1; k <= 15; k++) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("midrst stall", stall_div, 0);
      check("midrst ready", ready, 0);
      check("midrst result", result, 0);
      last_res = '0;
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      single('{"after_rst", 1'b0, 32'd1000, 32'd10, 32'd0, 32'd100});

      check("scoreboard empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
